// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman packer and its downstream decoder.
// Holds the symbol/length widths, the escape-code layout, the emitter FSM
// state type and the fixed prefix-code table. Codes are stored
// right-aligned. The first stream bit is the MSB of the code's length.
package huff_pkg;

    localparam int unsigned SYM_W      = 4;
    localparam int unsigned LEN_W      = 3;
    localparam logic [2:0]  ESC_PREFIX = 3'b000;
    localparam int unsigned ESC_LEN    = 7;

    typedef enum logic [0:0] {
        StIdle,
        StGap
    } state_e;

    // Code table: right-aligned code plus its length.
    localparam logic [3:0]       CODE_ZERO = 4'b0001;  // 0  -> 1
    localparam logic [LEN_W-1:0] LEN_ZERO  = 3'd1;
    localparam logic [3:0]       CODE_P1   = 4'b0010;  // +1 -> 010
    localparam logic [LEN_W-1:0] LEN_P1    = 3'd3;
    localparam logic [3:0]       CODE_M1   = 4'b0011;  // -1 -> 011
    localparam logic [LEN_W-1:0] LEN_M1    = 3'd3;
    localparam logic [3:0]       CODE_P2   = 4'b0010;  // +2 -> 0010
    localparam logic [LEN_W-1:0] LEN_P2    = 3'd4;
    localparam logic [3:0]       CODE_M2   = 4'b0011;  // -2 -> 0011
    localparam logic [LEN_W-1:0] LEN_M2    = 3'd4;

endpackage

// File: rtl/huff_code_lut.sv
// Combinational symbol-to-prefix-code lookup.
// Ports:
//   sym_data  in   signed 4-bit symbol
//   code      out  code word, right-aligned in MAX_CODE bits
//   len       out  number of valid code bits
// Any symbol outside the short-code table uses the escape form:
// ESC_PREFIX followed by the raw 4-bit two's complement value.
module huff_code_lut
    import huff_pkg::*;
#(
    parameter int unsigned MAX_CODE = 9
) (
    input  logic [SYM_W-1:0]    sym_data,
    output logic [MAX_CODE-1:0] code,
    output logic [LEN_W-1:0]    len
);

    always_comb begin
        code = MAX_CODE'({ESC_PREFIX, sym_data});
        len  = LEN_W'(ESC_LEN);
        case (sym_data)
            4'h0: begin code = MAX_CODE'(CODE_ZERO); len = LEN_ZERO; end
            4'h1: begin code = MAX_CODE'(CODE_P1);   len = LEN_P1;   end
            4'hF: begin code = MAX_CODE'(CODE_M1);   len = LEN_M1;   end
            4'h2: begin code = MAX_CODE'(CODE_P2);   len = LEN_P2;   end
            4'hE: begin code = MAX_CODE'(CODE_M2);   len = LEN_M2;   end
            default: ;
        endcase
    end

endmodule

// File: rtl/huffman_packer.sv
// Huffman bit packer feeding the shift_reg decoder.
// Symbols arrive on a valid/ready handshake, are mapped to prefix codes and
// appended MSB-first to a bit buffer. Chunks of up to CHUNK bits are pushed
// out on a one-cycle sValid strobe, spaced by at least GAP idle cycles.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   sym_valid  in   symbol offered
//   sym_data   in   signed 4-bit symbol
//   sym_ready  out  symbol accepted on an edge with valid && ready
//   flush      in   pulse: drain every buffered bit, including a partial chunk
//   sValid     out  one-cycle chunk strobe
//   in_bits    out  chunk, right-aligned, first stream bit at in_bits[in_len-1]
//   in_len     out  valid bits in chunk (1..CHUNK)
//   busy       out  buffer non-empty, flush pending or emitter not idle
// Optional feature macro HUFF_PACKER_STATS_EN adds saturating counters:
//   stat_syms  out  accepted symbols
//   stat_bits  out  emitted bits
module huffman_packer
    import huff_pkg::*;
#(
    parameter int unsigned MAX_CODE = 9,
    parameter int unsigned BUF_W    = 16,
    parameter int unsigned CHUNK    = 4,
    parameter int unsigned GAP      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    output logic             sym_ready,
    input  logic             flush,
    output logic             sValid,
    output logic [CHUNK-1:0] in_bits,
    output logic [LEN_W-1:0] in_len,
    output logic             busy
`ifdef HUFF_PACKER_STATS_EN
    ,
    output logic [15:0]      stat_syms,
    output logic [15:0]      stat_bits
`endif
);

    localparam int unsigned CNT_W = $clog2(BUF_W + 1);
    localparam int unsigned GAP_W = $clog2(GAP + 1);

    state_e             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [BUF_W-1:0]   bits_q, bits_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               flush_pending_q, flush_pending_d;
    logic               svalid_q, svalid_d;
    logic [CHUNK-1:0]   in_bits_q, in_bits_d;
    logic [LEN_W-1:0]   in_len_q, in_len_d;

    logic               accept;
    logic               emit;
    logic [CNT_W-1:0]   emit_n;
    logic [CNT_W-1:0]   rem;
    logic [CNT_W:0]     fill_sum;
    logic [CNT_W:0]     ins_shift;
    logic [CHUNK-1:0]   head;
    logic [CNT_W-1:0]   head_shift;
    logic [MAX_CODE-1:0] code;
    logic [LEN_W-1:0]   code_len;

    huff_code_lut #(
        .MAX_CODE (MAX_CODE)
    ) u_lut (
        .sym_data (sym_data),
        .code     (code),
        .len      (code_len)
    );

    // Ready only when the longest code is guaranteed to fit.
    assign sym_ready = !flush_pending_q &&
                       (({1'b0, count_q} + (CNT_W+1)'(MAX_CODE)) <= (CNT_W+1)'(BUF_W));
    assign accept    = sym_valid && sym_ready;
    assign busy      = (count_q != '0) || flush_pending_q || (state_q != StIdle);

    assign sValid  = svalid_q;
    assign in_bits = in_bits_q;
    assign in_len  = in_len_q;

    always_comb begin
        state_d         = state_q;
        gap_d           = gap_q;
        flush_pending_d = flush_pending_q;
        svalid_d        = 1'b0;
        in_bits_d       = in_bits_q;
        in_len_d        = in_len_q;
        emit            = 1'b0;
        emit_n          = '0;

        unique case (state_q)
            StIdle: begin
                if (count_q >= CNT_W'(CHUNK)) begin
                    emit   = 1'b1;
                    emit_n = CNT_W'(CHUNK);
                end else if (flush_pending_q && (count_q != '0)) begin
                    emit   = 1'b1;
                    emit_n = count_q;
                end else if (flush_pending_q) begin
                    flush_pending_d = 1'b0;
                end
            end
            StGap: begin
                gap_d = gap_q - 1'b1;
                if (gap_q <= GAP_W'(1)) begin
                    state_d = StIdle;
                end
            end
        endcase

        // A second flush while one is pending is ignored.
        if (flush && !flush_pending_q) begin
            flush_pending_d = 1'b1;
        end

        // Oldest bits sit at the MSB; a partial chunk is right-aligned.
        head       = bits_q[BUF_W-1 -: CHUNK];
        head_shift = CNT_W'(CHUNK) - emit_n;
        if (emit) begin
            state_d   = StGap;
            gap_d     = GAP_W'(GAP);
            svalid_d  = 1'b1;
            in_bits_d = head >> head_shift;
            in_len_d  = LEN_W'(emit_n);
        end

        // Emit and accept may share an edge: new code lands behind the survivors.
        rem       = count_q - emit_n;
        fill_sum  = {1'b0, rem} + (accept ? (CNT_W+1)'(code_len) : '0);
        ins_shift = (CNT_W+1)'(BUF_W) - fill_sum;
        bits_d    = bits_q << emit_n;
        if (accept) begin
            bits_d = bits_d | (BUF_W'(code) << ins_shift);
        end
        count_d = fill_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            gap_q           <= '0;
            bits_q          <= '0;
            count_q         <= '0;
            flush_pending_q <= 1'b0;
            svalid_q        <= 1'b0;
            in_bits_q       <= '0;
            in_len_q        <= '0;
        end else begin
            state_q         <= state_d;
            gap_q           <= gap_d;
            bits_q          <= bits_d;
            count_q         <= count_d;
            flush_pending_q <= flush_pending_d;
            svalid_q        <= svalid_d;
            in_bits_q       <= in_bits_d;
            in_len_q        <= in_len_d;
        end
    end

    bits_no_overflow_a : assert property (
        @(posedge clk) disable iff (reset) fill_sum <= (CNT_W+1)'(BUF_W)
    );

`ifdef HUFF_PACKER_STATS_EN
    logic [15:0] stat_syms_q;
    logic [15:0] stat_bits_q;
    logic [16:0] bits_sum;

    assign bits_sum = {1'b0, stat_bits_q} + 17'(emit_n);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_syms_q <= '0;
            stat_bits_q <= '0;
        end else begin
            if (accept && (stat_syms_q != 16'hFFFF)) begin
                stat_syms_q <= stat_syms_q + 16'd1;
            end
            stat_bits_q <= bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
        end
    end

    assign stat_syms = stat_syms_q;
    assign stat_bits = stat_bits_q;
`endif

endmodule

// File: doc/huffman_packer.md
# huffman_packer

- Upstream neighbour of the `shift_reg` Huffman decoder.
- Accepts signed 4-bit symbols over a valid/ready handshake and maps each to a variable-length prefix code through a fixed table.
- Appends codes MSB-first into a bit buffer, then emits chunks of at most 4 bits on `sValid`/`in_bits`/`in_len`.
- Paces chunks with a programmable idle gap so the decoder can drain its window between pushes.

## Interface
- `MAX_CODE`, 9: longest code the buffer must always be able to absorb.
- `BUF_W`, 16: bit-buffer depth.
- `CHUNK`, 4: maximum bits per emitted chunk; fixed by the `in_bits` width.
- `GAP`, 5: minimum low cycles on `sValid` between two pulses.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sym_valid`  in  1  symbol offered.
- `sym_data`  in  4  signed symbol, -8..7.
- `sym_ready`  out  1  symbol accepted on an edge where valid && ready.
- `flush`  in  1  one-cycle pulse: emit all buffered bits, including a partial chunk.
- `sValid`  out  1  one-cycle chunk strobe to the decoder.
- `in_bits`  out  4  chunk, right-aligned; first stream bit at `in_bits[in_len-1]`; unused upper bits are 0.
- `in_len`  out  3  valid bits in chunk, 1..4.
- `busy`  out  1  `(count != 0) || flush_pending || state != IDLE`.

## Operation
Code table (stream order):
- 0 → `1` (len 1)
- +1 → `010` (len 3)
- -1 → `011` (len 3)
- +2 → `0010` (len 4)
- -2 → `0011` (len 4)
- every other value → escape `000` followed by 4-bit two's complement, MSB first (len 7)

Buffer and handshake:
- Bit buffer `buf[BUF_W]` holds the oldest bit at the MSB side; `count` is its fill level.
- `sym_ready = !flush_pending && (count + MAX_CODE <= BUF_W)`, i.e. `count <= 7` at defaults. It is combinational from registered state.
- On accept, the code is appended behind the existing bits and `count += len`.

Emitter FSM:
- **IDLE**
  - If `count >= CHUNK`: emit 4 bits, go to GAP.
  - Else if `flush_pending && count > 0`: emit `count` bits, go to GAP.
  - Else if `flush_pending && count == 0`: clear `flush_pending`.
- **GAP**: `gap_cnt` is loaded with GAP on emit and decrements each cycle. Go to IDLE when it reaches 0.
- **Emit**: registers `in_bits`/`in_len`, sets `sValid` for exactly one cycle, removes those bits from the head, `count -= n`.

Boundary conditions:
- Accept and emit on the same edge: both apply, `count_next = count + len - n`, and the appended bits follow the remaining ones.
- `flush` arriving while `flush_pending` is already set is ignored. `flush` with an empty buffer and IDLE clears within 1 cycle and produces no pulse.
- Overflow is impossible by construction. Any attempt to exceed `BUF_W` is a design error and is asserted in simulation.
- `reset` mid-operation clears the buffer, count, FSM, `flush_pending` and `gap_cnt` immediately. No stale bits appear after release.

Reset values:
- `sValid`=0, `in_bits`=0, `in_len`=0, `busy`=0.
- `sym_ready`=1 (count=0, no flush).

## Timing
- Symbol accepted at edge e → the earliest `sValid` containing its first bit is high in the cycle after edge e+1 (1 cycle of latency).
- Pulse in cycle k → `sValid` is low for cycles k+1..k+GAP. The earliest next pulse is cycle k+GAP+1.
- `in_bits`/`in_len` hold their last values between pulses.
- `flush` seen at edge f → `flush_pending` is set from f and `sym_ready` is low from the cycle after f.

## Configuration
- `HUFF_PACKER_STATS_EN` defined: adds outputs `stat_syms` [15:0] and `stat_bits` [15:0].
  - Counts accepted symbols and emitted bits.
  - Both saturate at 16'hFFFF and are cleared by reset.
- Undefined: neither the ports nor the counters exist.

## Structure
- Package `huff_pkg` holds:
  - `SYM_W`=4, `LEN_W`=3, `ESC_PREFIX`=3'b000, `ESC_LEN`=7
  - the FSM state enum {IDLE, GAP}
  - the code-table constants shared with the decoder
- Sub-module `huff_code_lut`: combinational `sym_data` → {code[MAX_CODE-1:0] right-aligned, len}.

## Test plan
1. Four symbols 0 → after the 4th accept, one pulse with `in_bits`=4'b1111, `in_len`=4; `busy` drops after GAP.
2. Symbols +1 then 0 → one pulse with `in_bits`=4'b0101, `in_len`=4.
3. Symbol +5, then `flush` → pulse `in_bits`=4'b0000 len 4; GAP low cycles; pulse `in_bits`=4'b0101 len 3; then `busy`=0.
4. `sym_valid` held continuously with five -3 symbols → `sym_ready` deasserts when `count` > 7; output stream equals 5×`0001101`; pulses spaced exactly GAP+1 cycles.
5. Reset asserted during GAP with `count`=3 → `sValid`=0 and `busy`=0 immediately; after release, symbol 0×4 yields only `1111`.
6. IDLE with `count`=4 while -1 is accepted on the same edge → pulse carries the old 4 bits; `count`=3 afterwards; after `flush`, a pulse `in_bits`=4'b0011, len 3.
